sram_word_ctrl: RTL

//  Initiator side of the byte-wide async SRAM bus (nce/re/we/addr/8-bit tri-state data).

---
 rtl/sram_word_ctrl_pkg.sv | 50 +++++
 rtl/sram_wait_timer.sv | 31 +++
 rtl/sram_word_ctrl.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/sram_word_ctrl_pkg.sv
// Shared SRAM bus definitions: FSM encoding, word geometry and byte-lane helpers.
// Byte 0 of a word is the most significant (big-endian) and lives at the lowest address.
package sram_word_ctrl_pkg;

  localparam int WORD_BYTES  = 4;
  localparam int SRAM_ADDR_W = 11;
  localparam int SRAM_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  typedef struct packed {
    logic        we;
    logic [31:0] wdata;
    logic [3:0]  be;
  } req_t;

  function automatic logic [7:0] word_byte(input logic [31:0] w, input logic [1:0] i);
    logic [7:0] b;
    case (i)
      2'd0:    b = w[31:24];
      2'd1:    b = w[23:16];
      2'd2:    b = w[15:8];
      default: b = w[7:0];
    endcase
    return b;
  endfunction

  function automatic logic [31:0] set_byte(input logic [31:0] w, input logic [1:0] i,
                                           input logic [7:0] b);
    logic [31:0] r;
    r = w;
    case (i)
      2'd0:    r[31:24] = b;
      2'd1:    r[23:16] = b;
      2'd2:    r[15:8]  = b;
      default: r[7:0]   = b;
    endcase
    return r;
  endfunction

  // be[3] enables the byte at base+0, be[0] the byte at base+3.
  function automatic logic lane_en(input logic [3:0] be, input logic [1:0] i);
    return be[2'd3 - i];
  endfunction

endpackage

// File: rtl/sram_wait_timer.sv
// Per-access wait down-counter: load sets WAIT_CYC-1, en counts down, expire marks the last cycle.
// Latency: expire is combinational from the count; backpressure: none, caller owns sequencing.
// Backpressure: not applicable; the counter simply saturates at zero while enabled.
module sram_wait_timer #(
  parameter int WAIT_CYC = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic expire
);

  localparam int CW = (WAIT_CYC > 1) ? $clog2(WAIT_CYC) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(WAIT_CYC - 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= RELOAD;
    end else if (en && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign expire = (cnt_q == '0);

endmodule

// File: rtl/sram_word_ctrl.sv
// Word-to-byte sequencer driving a byte-wide async SRAM on behalf of the CPU memory stage.
// Latency: accept edge -> rsp_valid pulse in cycle 4*WAIT_CYC+1 (fixed, independent of byte enables).
// Backpressure: req_ready is low from accept through the response cycle; the CPU holds its request.
module sram_word_ctrl
  import sram_word_ctrl_pkg::*;
#(
  parameter int ADDR_W   = SRAM_ADDR_W,
  parameter int DATA_W   = SRAM_DATA_W,
  parameter int WAIT_CYC = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [3:0]        req_be,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              sram_nce,
  output logic              sram_re,
  output logic              sram_we,
  output logic [ADDR_W-1:0] sram_addr,
  inout  wire  [DATA_W-1:0] sram_data
);

  state_t              state_q, state_d;
  logic [1:0]          idx_q, idx_d;
  logic [ADDR_W-1:2]   base_q, base_d;
  req_t                req_q, req_d;
  logic [31:0]         rbuf_q, rbuf_d;

  logic                nce_d, re_d, we_d, rsp_valid_d;
  logic [ADDR_W-1:0]   addr_d;
  logic [31:0]         rsp_rdata_d;

  logic                tmr_load, tmr_en, tmr_expire;

  logic                unused_addr_lsb;
  assign unused_addr_lsb = ^req_addr[1:0];

  sram_wait_timer #(
    .WAIT_CYC(WAIT_CYC)
  ) u_wait (
    .clk   (clk),
    .rst   (rst),
    .load  (tmr_load),
    .en    (tmr_en),
    .expire(tmr_expire)
  );

  assign req_ready = (state_q == IDLE) & ~rst;

  // The write lane follows the registered idx, so it moves in step with sram_addr.
  assign sram_data = (sram_we && !sram_nce) ? word_byte(req_q.wdata, idx_q) : 'z;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    base_d      = base_q;
    req_d       = req_q;
    rbuf_d      = rbuf_q;
    nce_d       = sram_nce;
    re_d        = sram_re;
    we_d        = sram_we;
    addr_d      = sram_addr;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata;
    tmr_load    = 1'b0;
    tmr_en      = 1'b0;

    case (state_q)
      IDLE: begin
        if (req_valid && req_ready) begin
          base_d   = req_addr[ADDR_W-1:2];
          req_d    = '{we: req_we, wdata: req_wdata, be: req_be};
          idx_d    = 2'd0;
          tmr_load = 1'b1;
          state_d  = ACCESS;
          nce_d    = 1'b0;
          addr_d   = {req_addr[ADDR_W-1:2], 2'b00};
          re_d     = ~req_we;
          we_d     = req_we & lane_en(req_be, 2'd0);
        end
      end

      ACCESS: begin
        tmr_en = 1'b1;
        if (tmr_expire) begin
          if (!req_q.we) begin
            rbuf_d = set_byte(rbuf_q, idx_q, sram_data);
          end
          if (idx_q == 2'(WORD_BYTES - 1)) begin
            state_d     = DONE;
            nce_d       = 1'b1;
            re_d        = 1'b0;
            we_d        = 1'b0;
            rsp_valid_d = 1'b1;
            if (!req_q.we) begin
              rsp_rdata_d = rbuf_d;
            end
          end else begin
            idx_d    = idx_q + 2'd1;
            tmr_load = 1'b1;
            addr_d   = {base_q, idx_d};
            we_d     = req_q.we & lane_en(req_q.be, idx_d);
          end
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
        nce_d   = 1'b1;
        re_d    = 1'b0;
        we_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      idx_q     <= 2'd0;
      base_q    <= '0;
      req_q     <= '0;
      rbuf_q    <= '0;
      sram_nce  <= 1'b1;
      sram_re   <= 1'b0;
      sram_we   <= 1'b0;
      sram_addr <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      base_q    <= base_d;
      req_q     <= req_d;
      rbuf_q    <= rbuf_d;
      sram_nce  <= nce_d;
      sram_re   <= re_d;
      sram_we   <= we_d;
      sram_addr <= addr_d;
      rsp_valid <= rsp_valid_d;
      rsp_rdata <= rsp_rdata_d;
    end
  end

endmodule
